// File: rtl/spi_master_drive.sv
// spi_master_drive: SPI master PHY for fixed DATA_W-bit frames.
// Generates SCLK/CS_N/MOSI from the sequencer's spi_en/spi_mode/spi_sdata,
// captures MISO, and returns spi_rdata with a one-cycle spi_done per frame.
// Build option: define SPI_LSB_FIRST_EN to shift tx bit 0 first and fill rx
// from the MSB downward. Frame timing is the same in both builds.
//
// Sequencer contract: spi_en is a level, not a pulse. It is sampled in IDLE to
// start a frame and in DONE to chain the next frame with CS held low.
// spi_mode and spi_sdata are captured in LOAD. spi_done is high for exactly the
// DONE cycle, and spi_rdata is valid from that cycle until the next DONE.
// spi_state exposes the FSM state (0 IDLE, 1 LOAD, 2 SHIFT, 3 DONE) for debug.
module spi_master_drive #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              spi_en,
  input  logic [1:0]        spi_mode,
  input  logic [DATA_W-1:0] spi_sdata,
  output logic              spi_done,
  output logic [DATA_W-1:0] spi_rdata,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [1:0]        spi_state
);

  localparam int EDGE_N = 2 * DATA_W;
  localparam int EDGE_W = $clog2(EDGE_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [7:0]          div_cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   tx_shift;
  logic [DATA_W-1:0]   rx_shift;
  logic [DATA_W-1:0]   rx_next;
  logic                tick;
  logic                last_edge;
  logic                leading;
  logic                sample_now;
  logic                drive_now;

  // Bit that goes out on the wire next from a tx word.
  function automatic logic tx_head(input logic [DATA_W-1:0] v);
`ifdef SPI_LSB_FIRST_EN
    return v[0];
`else
    return v[DATA_W-1];
`endif
  endfunction

  // Tx word after its head bit has been sent.
  function automatic logic [DATA_W-1:0] tx_step(input logic [DATA_W-1:0] v);
`ifdef SPI_LSB_FIRST_EN
    return v >> 1;
`else
    return v << 1;
`endif
  endfunction

  assign spi_state = state_q;

  // Edge strobes: tick is the sys_clk cycle in which an SCLK edge is issued.
  always_comb begin
    tick       = 1'b0;
    last_edge  = 1'b0;
    leading    = ~edge_cnt[0];
    sample_now = 1'b0;
    drive_now  = 1'b0;
    rx_next    = rx_shift;
    if (state_q == SHIFT && div_cnt == 8'(CLK_DIV - 1)) begin
      tick = 1'b1;
    end
    last_edge = tick && (edge_cnt == EDGE_W'(EDGE_N - 1));
    if (mode_q[0]) begin
      // CPHA=1: drive on leading, sample on trailing
      sample_now = tick && !leading;
      drive_now  = tick && leading;
    end else begin
      // CPHA=0: first bit is pre-driven in LOAD, so no drive after the final edge
      sample_now = tick && leading;
      drive_now  = tick && !leading && !last_edge;
    end
    if (sample_now) begin
`ifdef SPI_LSB_FIRST_EN
      rx_next = {spi_miso, rx_shift[DATA_W-1:1]};
`else
      rx_next = {rx_shift[DATA_W-2:0], spi_miso};
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: frames chain through DONE while spi_en stays high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (spi_en) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (last_edge) state_d = DONE;
      DONE:    state_d = spi_en ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered pin outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      spi_done  <= 1'b0;
      spi_rdata <= '0;
      spi_sclk  <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_mosi  <= 1'b0;
      div_cnt   <= '0;
      edge_cnt  <= '0;
      mode_q    <= 2'b00;
      tx_shift  <= '0;
      rx_shift  <= '0;
    end else begin
      spi_done <= 1'b0;
      case (state_q)
        IDLE: begin
          // CS drops together with the move into LOAD
          spi_cs_n <= ~spi_en;
          spi_sclk <= spi_mode[1];
        end
        LOAD: begin
          spi_cs_n <= 1'b0;
          spi_sclk <= spi_mode[1];
          mode_q   <= spi_mode;
          div_cnt  <= '0;
          edge_cnt <= '0;
          rx_shift <= '0;
          if (!spi_mode[0]) begin
            spi_mosi <= tx_head(spi_sdata);
            tx_shift <= tx_step(spi_sdata);
          end else begin
            tx_shift <= spi_sdata;
          end
        end
        SHIFT: begin
          div_cnt  <= tick ? 8'd0 : div_cnt + 8'd1;
          rx_shift <= rx_next;
          if (tick) begin
            spi_sclk <= ~spi_sclk;
            edge_cnt <= edge_cnt + 1'b1;
          end
          if (drive_now) begin
            spi_mosi <= tx_head(tx_shift);
            tx_shift <= tx_step(tx_shift);
          end
          if (last_edge) begin
            spi_done  <= 1'b1;
            spi_rdata <= rx_next;
          end
        end
        DONE: begin
          // Held low when chaining, released next cycle otherwise
          spi_cs_n <= ~spi_en;
        end
        default: begin
          spi_cs_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_drive.sv
// tb_spi_master_drive: directed bench for spi_master_drive with a scoreboard
// on spi_rdata and a behavioural SPI slave that checks the MOSI word per frame.
module tb_spi_master_drive;

  localparam int DATA_W  = 16;
  localparam int CLK_DIV = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              spi_en = 1'b0;
  logic [1:0]        spi_mode = 2'b00;
  logic [DATA_W-1:0] spi_sdata = '0;
  logic              spi_done;
  logic [DATA_W-1:0] spi_rdata;
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic [1:0]        spi_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_mosi_q[$];
  logic [DATA_W-1:0] miso_q[$];

  logic [1:0] cur_mode = 2'b00;
  logic       loopback = 1'b0;
  int         done_cnt = 0;
  int         toggles = 0;
  int         rises = 0;

  // clock / reset
  always #10 sys_clk = ~sys_clk;

  spi_master_drive #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .spi_en    (spi_en),
    .spi_mode  (spi_mode),
    .spi_sdata (spi_sdata),
    .spi_done  (spi_done),
    .spi_rdata (spi_rdata),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .spi_state (spi_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wire position of the k-th transmitted bit.
  function automatic int bidx(input int k);
`ifdef SPI_LSB_FIRST_EN
    return k;
`else
    return DATA_W - 1 - k;
`endif
  endfunction

  // ---------------- SPI slave model ----------------
  logic              s_miso = 1'b0;
  logic [DATA_W-1:0] s_word = '0;
  logic [DATA_W-1:0] s_cap = '0;
  int                s_edge = 0;
  int                s_bit = 0;
  logic              s_sclk_prev = 1'b0;
  logic              s_cs_prev = 1'b1;
  logic              s_done_prev = 1'b0;

  assign spi_miso = loopback ? spi_mosi : s_miso;

  // Slave reacts half a cycle after each observed SCLK edge.
  always @(negedge sys_clk) begin
    if (spi_cs_n) begin
      s_edge = 0;
    end else if (s_cs_prev || s_done_prev) begin
      // LOAD cycle of a new frame
      s_word = (miso_q.size() > 0) ? miso_q.pop_front() : '0;
      s_edge = 0;
      s_bit  = 0;
      s_cap  = '0;
      if (!cur_mode[0]) s_miso = s_word[bidx(0)];
    end else if (spi_sclk !== s_sclk_prev) begin
      if (!cur_mode[0]) begin
        if (s_edge % 2 == 0) begin
          s_cap[bidx(s_bit)] = spi_mosi;
        end else begin
          s_bit++;
          if (s_bit < DATA_W) s_miso = s_word[bidx(s_bit)];
        end
      end else begin
        if (s_edge % 2 == 0) begin
          s_miso = s_word[bidx(s_bit)];
        end else begin
          s_cap[bidx(s_bit)] = spi_mosi;
          s_bit++;
        end
      end
      s_edge++;
      if (s_edge == 2 * DATA_W) begin
        if (exp_mosi_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL mosi_word: got 0x%0h expected none", s_cap);
        end else begin
          check("mosi_word", s_cap, exp_mosi_q.pop_front());
        end
        s_edge = 0;
      end
    end
    s_sclk_prev = spi_sclk;
    s_cs_prev   = spi_cs_n;
    s_done_prev = spi_done;
  end

  // SCLK edge counter while CS is asserted
  logic e_prev = 1'b0;
  always @(negedge sys_clk) begin
    if (!spi_cs_n && spi_sclk !== e_prev) begin
      toggles++;
      if (spi_sclk) rises++;
    end
    e_prev = spi_sclk;
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge sys_clk) begin
    if (spi_done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: rdata 0x%0h expected no done", spi_rdata);
      end else begin
        check("rdata", spi_rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic first_bit(input logic [DATA_W-1:0] v);
`ifdef SPI_LSB_FIRST_EN
    return v[0];
`else
    return v[DATA_W-1];
`endif
  endfunction

  // Returns at the negedge of the LOAD cycle (CS just went low).
  task automatic wait_load(input string tag);
    int t;
    t = 0;
    while (spi_cs_n && t < 20) begin
      @(negedge sys_clk);
      t++;
    end
    check({tag, " cs_low"}, spi_cs_n, 1'b0);
  endtask

  task automatic single_frame(input string tag, input logic [1:0] mode,
                              input logic [DATA_W-1:0] sdata,
                              input logic [DATA_W-1:0] mword,
                              input logic [DATA_W-1:0] exp_rd, input int en_hold);
    int n;
    int d0;
    @(negedge sys_clk);
    spi_mode  = mode;
    cur_mode  = mode;
    spi_sdata = sdata;
    miso_q.push_back(mword);
    exp_q.push_back(exp_rd);
    exp_mosi_q.push_back(sdata);
    repeat (2) @(negedge sys_clk);
    check({tag, " sclk_idle"}, spi_sclk, mode[1]);
    toggles = 0;
    rises = 0;
    d0 = done_cnt;
    spi_en = 1'b1;
    wait_load(tag);
    if (en_hold == 0) spi_en = 1'b0;
    n = 0;
    while (spi_done !== 1'b1 && n < 300) begin
      @(negedge sys_clk);
      n++;
      if (n == en_hold) spi_en = 1'b0;
      if (n == 2 && !mode[0]) check({tag, " mosi_first"}, spi_mosi, first_bit(sdata));
    end
    check({tag, " done_latency"}, n, 129);
    @(negedge sys_clk);
    check({tag, " cs_release"}, spi_cs_n, 1'b1);
    check({tag, " sclk_end"}, spi_sclk, mode[1]);
    check({tag, " sclk_toggles"}, toggles, 2 * DATA_W);
    check({tag, " sclk_rises"}, rises, DATA_W);
    check({tag, " done_count"}, done_cnt, d0 + 1);
  endtask

  task automatic three_frames();
    int n;
    int glitch;
    int d0;
    @(negedge sys_clk);
    spi_mode  = 2'b11;
    cur_mode  = 2'b11;
    spi_sdata = 16'h9000;
    miso_q.push_back(16'h0000); miso_q.push_back(16'h0000); miso_q.push_back(16'hEF16);
    exp_q.push_back(16'h0000);  exp_q.push_back(16'h0000);  exp_q.push_back(16'hEF16);
    exp_mosi_q.push_back(16'h9000); exp_mosi_q.push_back(16'h0000); exp_mosi_q.push_back(16'h0000);
    repeat (2) @(negedge sys_clk);
    d0 = done_cnt;
    glitch = 0;
    spi_en = 1'b1;
    wait_load("seq");
    for (int f = 0; f < 3; f++) begin
      n = 0;
      do begin
        @(negedge sys_clk);
        n++;
        if (spi_cs_n !== 1'b0) glitch++;
      end while (spi_done !== 1'b1 && n < 300);
      check("seq done_spacing", n, (f == 0) ? 129 : 130);
      // sequencer update on the DONE negedge
      spi_sdata = 16'h0000;
      if (f == 2) spi_en = 1'b0;
    end
    check("seq cs_glitch", glitch, 0);
    @(negedge sys_clk);
    check("seq cs_release", spi_cs_n, 1'b1);
    check("seq done_count", done_cnt, d0 + 3);
  endtask

  task automatic reset_mid_frame();
    int d0;
    @(negedge sys_clk);
    spi_mode  = 2'b00;
    cur_mode  = 2'b00;
    spi_sdata = 16'hA5A5;
    miso_q.push_back(16'hFFFF);
    repeat (2) @(negedge sys_clk);
    spi_en = 1'b1;
    wait_load("rst");
    d0 = done_cnt;
    repeat (60) @(negedge sys_clk);
    check("rst toggles_before", toggles >= 15, 1'b1);
    sys_rst_n = 1'b0;
    spi_en = 1'b0;
    #1;
    check("rst cs_n", spi_cs_n, 1'b1);
    check("rst sclk", spi_sclk, 1'b0);
    check("rst rdata", spi_rdata, 16'h0000);
    check("rst done", spi_done, 1'b0);
    check("rst state", spi_state, 2'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (150) @(negedge sys_clk);
    check("rst no_done", done_cnt, d0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    sys_rst_n = 1'b1;
    #1;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset cs_n", spi_cs_n, 1'b1);
    check("reset sclk", spi_sclk, 1'b0);
    check("reset done", spi_done, 1'b0);
    check("reset rdata", spi_rdata, 16'h0000);
    check("reset mosi", spi_mosi, 1'b0);
    check("reset state", spi_state, 2'd0);
    sys_rst_n = 1'b1;

    single_frame("mode3", 2'b11, 16'h9000, 16'hA5C3, 16'hA5C3, 0);
    three_frames();
    single_frame("mode0", 2'b00, 16'h8001, 16'h3C5A, 16'h3C5A, 0);
    loopback = 1'b1;
    single_frame("mode1_loop", 2'b01, 16'h1234, 16'h0000, 16'h1234, 0);
    single_frame("mode2_loop", 2'b10, 16'h1234, 16'h0000, 16'h1234, 0);
    loopback = 1'b0;
    single_frame("en_drop", 2'b00, 16'h0F0F, 16'h5AA5, 16'h5AA5, 46);
    repeat (140) @(negedge sys_clk);
    reset_mid_frame();
    single_frame("post_rst", 2'b00, 16'hC33C, 16'h0F0F, 16'h0F0F, 0);

    repeat (5) @(negedge sys_clk);
    check("rdata_queue_empty", exp_q.size(), 0);
    check("mosi_queue_empty", exp_mosi_q.size(), 0);
    check("miso_queue_empty", miso_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_master_drive.md
Name: spi_master_drive

Overview:
- 16-bit-frame SPI master PHY that sits directly downstream of the flash/peripheral configuration sequencer.
- Accepts spi_en, spi_mode and spi_sdata from the sequencer, generates SCLK/CS_N/MOSI, captures MISO, and returns spi_rdata with a one-cycle spi_done per frame.
- CS_N stays low across back-to-back frames while spi_en is held, so multi-frame flash commands (e.g. 0x90 read-ID) are one transaction.

Parameters:
- CLK_DIV, 4: sys_clk cycles per SCLK half-period; legal values 2..255.
- DATA_W, 16: frame width in bits.

Ports:
- sys_clk  input  1  system clock, 50 MHz
- sys_rst_n  input  1  asynchronous active-low reset
- spi_en  input  1  level; high = run frames continuously, low = finish current frame then release CS
- spi_mode  input  2  [1]=CPOL, [0]=CPHA; latched per frame
- spi_sdata  input  DATA_W  transmit word; latched per frame
- spi_done  output  1  one-cycle pulse at end of each frame
- spi_rdata  output  DATA_W  last received word
- spi_sclk  output  1  SPI clock
- spi_cs_n  output  1  chip select, active low
- spi_mosi  output  1  serial data out
- spi_miso  input  1  serial data in

Behaviour:
- All outputs registered on posedge sys_clk.
- Reset values: spi_done=0, spi_rdata=0, spi_sclk=0, spi_cs_n=1, spi_mosi=0, state=IDLE, all counters 0.
- IDLE:
  - spi_cs_n=1; spi_sclk follows spi_mode[1].
  - spi_en sampled high -> LOAD.
- LOAD (1 cycle):
  - spi_cs_n=0.
  - Latch spi_sdata into tx shifter and spi_mode into the mode register.
  - Clear div_cnt and edge_cnt.
  - If CPHA=0, spi_mosi = tx MSB.
  - -> SHIFT.
- SHIFT:
  - div_cnt counts 0..CLK_DIV-1; at terminal count spi_sclk toggles and edge_cnt increments (0..2*DATA_W-1).
  - Even edge_cnt = leading edge; odd = trailing edge.
  - CPHA=0: sample spi_miso on leading edges; shift out next MOSI bit on trailing edges, except the last.
  - CPHA=1: drive MOSI bit on leading edges; sample spi_miso on trailing edges.
  - Sampling registers spi_miso in the same sys_clk cycle the sampling edge is issued.
  - After edge 2*DATA_W-1: spi_sclk is back at CPOL -> DONE.
- DONE (1 cycle):
  - spi_done=1 and spi_rdata <= rx shifter; spi_rdata holds until the next DONE.
  - spi_en high -> LOAD; spi_cs_n stays 0 with no high glitch.
  - spi_en low -> IDLE; spi_cs_n=1 next cycle.
  - The sequencer updates spi_sdata/spi_en on the negedge of the DONE cycle, so the next LOAD sees the new values.
- Frame length: LOAD-to-DONE = 1 + 2*DATA_W*CLK_DIV cycles (129 at defaults); frame period 130 cycles.
- spi_en falling mid-frame: ignored; the frame completes, then IDLE.
- spi_mode/spi_sdata changes mid-frame: ignored (latched values are used).
- Async reset mid-frame: immediate return to reset values; no spi_done; partial rx data discarded.
- Bit order: MSB first.

Optional Feature:
- SPI_LSB_FIRST_EN defined: tx shifts out bit 0 first and rx fills from MSB downward, so spi_rdata bit 0 holds the first received bit.
- Undefined: MSB first on both tx and rx (default).
- Timing is identical in both builds.

Test Plan:
- Mode 3, CLK_DIV=4, spi_sdata=0x9000, MISO model returns 0xA5C3:
  - spi_sclk idles 1 with 16 rising edges.
  - MOSI sampled on rising edges = 1001_0000_0000_0000.
  - spi_done exactly 129 cycles after LOAD; spi_rdata=0xA5C3.
- Three frames 0x9000/0x0000/0x0000, spi_en dropped on the third DONE negedge:
  - spi_cs_n low continuously for 3 frames.
  - Done pulses 130 cycles apart.
  - spi_cs_n=1 one cycle after the third done.
  - Flash model ID 0xEF16 appears in the final spi_rdata.
- Mode 0, spi_sdata=0x8001, MISO=0x3C5A:
  - spi_sclk idles 0; MOSI=1 before the first rising edge.
  - Last bit 1 sampled; spi_rdata=0x3C5A.
- Modes 1 and 2, loopback MOSI->MISO with 0x1234 -> spi_rdata=0x1234 in both modes; sclk idle level matches CPOL.
- spi_en dropped after edge 10 -> all 32 edges still occur, spi_done pulses once, then IDLE with spi_cs_n=1.
- sys_rst_n asserted at edge 14 -> spi_cs_n=1, spi_sclk=0, spi_rdata=0 immediately; no spi_done; after release, a new frame works normally.
